pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards, redirects on taken beq/jump resolved in EX, and freezes the whole pipe while data memory is busy.
- Sits beside the pipeline registers. It owns no datapath and only sequences the registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 59 +++++
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer states, control bundles and the hazard check.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // ID/EX control fields of the datapath register
  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic       regDst;
    logic [1:0] aluOp;
  } idExCtrl_t;

  // Bubble: every ID/EX control field cleared
  localparam idExCtrl_t ID_EX_BUBBLE = '0;

  // Register enables/flushes driven by the sequencer
  typedef struct packed {
    logic pcEn;
    logic ifIdEn;
    logic ifIdFlush;
    logic idExEn;
    logic idExFlush;
    logic exMemEn;
    logic redirect;
  } hzCtrl_t;

  localparam hzCtrl_t CTRL_RUN    = 7'b1101010;
  localparam hzCtrl_t CTRL_FREEZE = 7'b0000000;
  localparam hzCtrl_t CTRL_RESET  = 7'b1111110;
  localparam hzCtrl_t CTRL_BUBBLE = 7'b0001110;
  localparam hzCtrl_t CTRL_REDIR  = 7'b1111111;

  // Load in EX writes a register the ID instruction reads
  function automatic logic loadUse(
    input logic       memToReg,
    input logic       regWrite,
    input logic [4:0] exRt,
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       usesRt
  );
    loadUse = memToReg && regWrite &&
              (exRt != REG_ZERO) &&
              ((exRt == idRs) ||
               (usesRt && (exRt == idRt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between pipeline and sequencer.
// Pipeline (master) supplies hazard inputs, sequencer drives controls.
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_to_reg;
  logic       ex_reg_write;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       ex_jump;
  logic       mem_busy;

  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       redirect;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output ex_mem_to_reg, ex_reg_write, ex_rt,
    output ex_branch_taken, ex_jump, mem_busy,
    input  pc_en, if_id_en, if_id_flush,
    input  id_ex_en, id_ex_flush, ex_mem_en,
    input  redirect
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  ex_mem_to_reg, ex_reg_write, ex_rt,
    input  ex_branch_taken, ex_jump, mem_busy,
    output pc_en, if_id_en, if_id_flush,
    output id_ex_en, id_ex_flush, ex_mem_en,
    output redirect
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count up on inc, stick at max, clear wins
  always_ff @(posedge clk) begin
    if (clr)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Handles load-use bubbles, EX redirects and memory-busy freezes.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
  output logic                  mem_timeout
);

  localparam int WT = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WT-1:0] WLIM = WT'(MEM_TIMEOUT);

  state_t        state, stateNxt;
  logic [WT-1:0] waitCnt, waitCntNxt;
  logic          timeoutNxt;
  hzCtrl_t       ctrl;
  logic          busy, redirReq, hazard;

  assign busy     = hz.mem_busy;
  assign redirReq = !busy &&
                    (hz.ex_branch_taken || hz.ex_jump);
  assign hazard   = !busy && !redirReq &&
                    loadUse(hz.ex_mem_to_reg,
                            hz.ex_reg_write,
                            hz.ex_rt, hz.id_rs,
                            hz.id_rt, hz.id_uses_rt);

  // State, wait counter and sticky timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= stateNxt;
      waitCnt     <= waitCntNxt;
      mem_timeout <= timeoutNxt;
    end
  end

  // Next state and register controls
  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    timeoutNxt = mem_timeout;
    ctrl       = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (state == MEM_WAIT && busy) begin
      ctrl = CTRL_FREEZE;
      if (waitCnt != WLIM)
        waitCntNxt = waitCnt + WT'(1);
      if (waitCntNxt == WLIM)
        timeoutNxt = 1'b1;
    end else begin
      stateNxt   = RUN;
      waitCntNxt = '0;
      unique case (1'b1)
        busy: begin
          ctrl       = CTRL_FREEZE;
          stateNxt   = MEM_WAIT;
          waitCntNxt = WT'(1);
        end
        redirReq: ctrl = CTRL_REDIR;
        hazard:   ctrl = CTRL_BUBBLE;
        default:  ctrl = CTRL_RUN;
      endcase
    end
  end

  assign hz.pc_en       = ctrl.pcEn;
  assign hz.if_id_en    = ctrl.ifIdEn;
  assign hz.if_id_flush = ctrl.ifIdFlush;
  assign hz.id_ex_en    = ctrl.idExEn;
  assign hz.id_ex_flush = ctrl.idExFlush;
  assign hz.ex_mem_en   = ctrl.exMemEn;
  assign hz.redirect    = ctrl.redirect;

  sat_counter #(.W(CNT_W)) uStall (
    .clk   (clk),
    .clr   (rst),
    .inc   (!rst && !ctrl.pcEn),
    .value (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) uFlush (
    .clk   (clk),
    .clr   (rst),
    .inc   (!rst && ctrl.redirect),
    .value (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Small counters and short timeout expose saturation and timeout.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 3;
  localparam int MEM_TIMEOUT = 4;

  // {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,redirect}
  localparam logic [6:0] NORMAL = 7'b1101010;
  localparam logic [6:0] FROZEN = 7'b0000000;
  localparam logic [6:0] RSTOUT = 7'b1111110;
  localparam logic [6:0] BUBBLE = 7'b0001110;
  localparam logic [6:0] REDIR  = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic mem_timeout;
  logic [6:0] ctl;
  int tests = 0;
  int failed = 0;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hz),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  assign ctl = {hz.pc_en, hz.if_id_en, hz.if_id_flush,
                hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en,
                hz.redirect};

  task automatic idle();
    hz.id_rs = 5'd0;
    hz.id_rt = 5'd0;
    hz.id_uses_rt = 1'b0;
    hz.ex_mem_to_reg = 1'b0;
    hz.ex_reg_write = 1'b0;
    hz.ex_rt = 5'd0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_jump = 1'b0;
    hz.mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic setLoad(input logic [4:0] rt);
    hz.ex_mem_to_reg = 1'b1;
    hz.ex_reg_write = 1'b1;
    hz.ex_rt = rt;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    tests++;
    if (ctl !== RSTOUT) begin
      failed++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, RSTOUT);
    end
    tick();
    tests++;
    if (stall_cycles !== 3'd0 || flush_events !== 3'd0 ||
        mem_timeout !== 1'b0) begin
      failed++;
      $display("FAIL reset_regs got=%0d/%0d/%b exp=0/0/0",
               stall_cycles, flush_events, mem_timeout);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ctl !== NORMAL) begin
      failed++;
      $display("FAIL reset_release got=%b exp=%b", ctl, NORMAL);
    end
  endtask

  task automatic test_load_use();
    doReset();
    setLoad(5'd8);
    hz.id_rs = 5'd8;
    #1;
    tests++;
    if (ctl !== BUBBLE) begin
      failed++;
      $display("FAIL lu_rs got=%b exp=%b", ctl, BUBBLE);
    end
    tick();
    idle();
    #1;
    tests++;
    if (ctl !== NORMAL || stall_cycles !== 3'd1) begin
      failed++;
      $display("FAIL lu_resume got=%b/%0d exp=%b/1",
               ctl, stall_cycles, NORMAL);
    end
    setLoad(5'd8);
    hz.id_rs = 5'd3;
    hz.id_rt = 5'd8;
    hz.id_uses_rt = 1'b1;
    #1;
    tests++;
    if (ctl !== BUBBLE) begin
      failed++;
      $display("FAIL lu_rt got=%b exp=%b", ctl, BUBBLE);
    end
    tick();
    hz.ex_reg_write = 1'b0;
    #1;
    tests++;
    if (ctl !== NORMAL || stall_cycles !== 3'd2) begin
      failed++;
      $display("FAIL lu_nowrite got=%b/%0d exp=%b/2",
               ctl, stall_cycles, NORMAL);
    end
  endtask

  task automatic test_no_hazard();
    doReset();
    setLoad(5'd0);
    hz.id_rs = 5'd0;
    #1;
    tests++;
    if (ctl !== NORMAL) begin
      failed++;
      $display("FAIL nh_x0 got=%b exp=%b", ctl, NORMAL);
    end
    tick();
    setLoad(5'd9);
    hz.id_rs = 5'd1;
    hz.id_rt = 5'd9;
    hz.id_uses_rt = 1'b0;
    #1;
    tests++;
    if (ctl !== NORMAL) begin
      failed++;
      $display("FAIL nh_rt_unused got=%b exp=%b", ctl, NORMAL);
    end
    tick();
    tests++;
    if (stall_cycles !== 3'd0) begin
      failed++;
      $display("FAIL nh_stalls got=%0d exp=0", stall_cycles);
    end
  endtask

  task automatic test_branch_hazard();
    doReset();
    setLoad(5'd8);
    hz.id_rs = 5'd8;
    hz.ex_branch_taken = 1'b1;
    #1;
    tests++;
    if (ctl !== REDIR) begin
      failed++;
      $display("FAIL br_hz got=%b exp=%b", ctl, REDIR);
    end
    tick();
    idle();
    hz.ex_jump = 1'b1;
    #1;
    tests++;
    if (flush_events !== 3'd1 || stall_cycles !== 3'd0 ||
        ctl !== REDIR) begin
      failed++;
      $display("FAIL br_cnt got=%0d/%0d/%b exp=1/0/%b",
               flush_events, stall_cycles, ctl, REDIR);
    end
    tick();
    idle();
    #1;
    tests++;
    if (flush_events !== 3'd2 || ctl !== NORMAL) begin
      failed++;
      $display("FAIL jmp_cnt got=%0d/%b exp=2/%b",
               flush_events, ctl, NORMAL);
    end
  endtask

  task automatic test_mem_wait();
    doReset();
    hz.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hz.ex_jump = (i == 1);
      #1;
      tests++;
      if (ctl !== FROZEN) begin
        failed++;
        $display("FAIL mw_frozen%0d got=%b exp=%b", i, ctl, FROZEN);
      end
      tick();
    end
    idle();
    #1;
    tests++;
    if (ctl !== NORMAL || stall_cycles !== 3'd3 ||
        mem_timeout !== 1'b0 || flush_events !== 3'd0) begin
      failed++;
      $display("FAIL mw_release got=%b/%0d/%b/%0d exp=%b/3/0/0",
               ctl, stall_cycles, mem_timeout, flush_events, NORMAL);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic expTo;
    doReset();
    hz.mem_busy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expTo = (i >= MEM_TIMEOUT);
      tests++;
      if (mem_timeout !== expTo) begin
        failed++;
        $display("FAIL to_cycle%0d got=%b exp=%b",
                 i, mem_timeout, expTo);
      end
    end
    hz.mem_busy = 1'b0;
    #1;
    tests++;
    if (ctl !== NORMAL) begin
      failed++;
      $display("FAIL to_release got=%b exp=%b", ctl, NORMAL);
    end
    tick();
    tick();
    tests++;
    if (mem_timeout !== 1'b1 || stall_cycles !== 3'd6) begin
      failed++;
      $display("FAIL to_sticky got=%b/%0d exp=1/6",
               mem_timeout, stall_cycles);
    end
    hz.mem_busy = 1'b1;
    repeat (3) tick();
    tests++;
    if (stall_cycles !== 3'd7) begin
      failed++;
      $display("FAIL stall_sat got=%0d exp=7", stall_cycles);
    end
    doReset();
    #1;
    tests++;
    if (mem_timeout !== 1'b0 || stall_cycles !== 3'd0) begin
      failed++;
      $display("FAIL to_clear got=%b/%0d exp=0/0",
               mem_timeout, stall_cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    hz.ex_jump = 1'b1;
    tick();
    idle();
    hz.mem_busy = 1'b1;
    tick();
    tick();
    tests++;
    if (stall_cycles !== 3'd2 || flush_events !== 3'd1) begin
      failed++;
      $display("FAIL rmw_pre got=%0d/%0d exp=2/1",
               stall_cycles, flush_events);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ctl !== RSTOUT) begin
      failed++;
      $display("FAIL rmw_ctl got=%b exp=%b", ctl, RSTOUT);
    end
    tick();
    rst = 1'b0;
    hz.mem_busy = 1'b0;
    #1;
    tests++;
    if (ctl !== NORMAL || stall_cycles !== 3'd0 ||
        flush_events !== 3'd0) begin
      failed++;
      $display("FAIL rmw_post got=%b/%0d/%0d exp=%b/0/0",
               ctl, stall_cycles, flush_events, NORMAL);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    hz.ex_branch_taken = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      tests++;
      if (flush_events !== 3'((i > 7) ? 7 : i)) begin
        failed++;
        $display("FAIL b2b_flush%0d got=%0d exp=%0d",
                 i, flush_events, (i > 7) ? 7 : i);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
